ir_tx: RTL and testbench

- NEC-format infrared transmitter. It is the transmit counterpart of the team's ir_rx receiver.
- Accepts a 32-bit custom+data word through a start/busy/done handshake and emits the full frame: lead code, 32 pulse-distance bits MSB-first, stop mark.
- Drives two outputs:
  - A baseband mark signal, plus its inverted form, suitable for loopback into ir_rx's inverted input.
  - A carrier-modulated LED drive.
- Sits beside ir_rx under the top module, clocked from the 50 MHz board clock.

---
 rtl/ir_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_ir_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ir_tx
//  Purpose  : NEC-format infrared transmitter. Sends lead code, 32 pulse-
//             distance bits MSB-first and a stop mark, with a baseband
//             output, its inverse for loopback, and a carrier-gated LED drive.
//  Revision : 1.0  initial release
// ============================================================================
module ir_tx #(
    parameter int TICK_DIV      = 50,
    parameter int LEAD_MARK_US  = 9000,
    parameter int LEAD_SPACE_US = 4500,
    parameter int BIT_MARK_US   = 560,
    parameter int ZERO_SPACE_US = 560,
    parameter int ONE_SPACE_US  = 1690,
    parameter int CARRIER_DIV   = 1316
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_data,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ir_tx,
    output logic        o_ir_txb,
    output logic        o_ir_led
);

    // ------------------------------------------------------------------------
    // Counter widths and constant compare values
    // ------------------------------------------------------------------------
    localparam int c_PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CAR_W   = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int c_MAX_A   = (LEAD_MARK_US > LEAD_SPACE_US) ? LEAD_MARK_US : LEAD_SPACE_US;
    localparam int c_MAX_B   = (BIT_MARK_US > ZERO_SPACE_US) ? BIT_MARK_US : ZERO_SPACE_US;
    localparam int c_MAX_C   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_DUR_MAX = (c_MAX_C > ONE_SPACE_US) ? c_MAX_C : ONE_SPACE_US;
    localparam int c_DUR_W   = $clog2(c_DUR_MAX + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_CAR_W-1:0] c_CAR_LAST = c_CAR_W'(CARRIER_DIV - 1);
    localparam logic [c_CAR_W-1:0] c_CAR_HALF = c_CAR_W'(CARRIER_DIV / 2);

    localparam logic [c_DUR_W-1:0] c_LEAD_MARK  = c_DUR_W'(LEAD_MARK_US);
    localparam logic [c_DUR_W-1:0] c_LEAD_SPACE = c_DUR_W'(LEAD_SPACE_US);
    localparam logic [c_DUR_W-1:0] c_BIT_MARK   = c_DUR_W'(BIT_MARK_US);
    localparam logic [c_DUR_W-1:0] c_ZERO_SPACE = c_DUR_W'(ZERO_SPACE_US);
    localparam logic [c_DUR_W-1:0] c_ONE_SPACE  = c_DUR_W'(ONE_SPACE_US);

    localparam logic [5:0] c_LAST_BIT = 6'd31;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_STOP_MARK  = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_accept;

    logic [c_PRE_W-1:0]   r_pre;
    logic [c_DUR_W-1:0]   r_dur;
    logic [c_DUR_W-1:0]   w_dur_len;
    logic [31:0]          r_shift;
    logic [5:0]           r_bit_cnt;
    logic [c_CAR_W-1:0]   r_car;
    logic [c_CAR_W-1:0]   w_car_next;

    logic                 w_timed;
    logic                 w_tick;
    logic                 w_dur_end;
    logic                 w_next_mark;
    logic                 w_next_timed;
    logic                 w_enter_mark;

    logic                 r_busy;
    logic                 r_done;
    logic                 r_tx;
    logic                 r_led;

    // ------------------------------------------------------------------------
    // Timing decode: which states are tick-timed and how long the current one lasts
    // ------------------------------------------------------------------------
    assign w_timed   = (r_state == S_LEAD_MARK)  || (r_state == S_LEAD_SPACE) ||
                       (r_state == S_BIT_MARK)   || (r_state == S_BIT_SPACE)  ||
                       (r_state == S_STOP_MARK);
    assign w_tick    = w_timed && (r_pre == c_PRE_LAST);
    assign w_dur_end = w_tick && (r_dur == (w_dur_len - c_DUR_W'(1)));

    // Duration of the current state in ticks; a bit space depends on the bit being sent
    always_comb begin
        w_dur_len = c_BIT_MARK;
        case (r_state)
            S_LEAD_MARK:  w_dur_len = c_LEAD_MARK;
            S_LEAD_SPACE: w_dur_len = c_LEAD_SPACE;
            S_BIT_MARK:   w_dur_len = c_BIT_MARK;
            S_BIT_SPACE:  w_dur_len = r_shift[31] ? c_ONE_SPACE : c_ZERO_SPACE;
            S_STOP_MARK:  w_dur_len = c_BIT_MARK;
            default:      w_dur_len = c_BIT_MARK;
        endcase
    end

    // Next-state logic and frame acceptance
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_LEAD_MARK;
                end
            end
            S_LEAD_MARK: begin
                if (w_dur_end) w_next_state = S_LEAD_SPACE;
            end
            S_LEAD_SPACE: begin
                if (w_dur_end) w_next_state = S_BIT_MARK;
            end
            S_BIT_MARK: begin
                if (w_dur_end) w_next_state = S_BIT_SPACE;
            end
            S_BIT_SPACE: begin
                if (w_dur_end) begin
                    w_next_state = (r_bit_cnt == c_LAST_BIT) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_STOP_MARK: begin
                if (w_dur_end) w_next_state = S_DONE;
            end
            S_DONE: begin
                // DONE is a single cycle; a waiting request chains straight into a new frame
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_LEAD_MARK;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state so the registered outputs line up with it
    // ------------------------------------------------------------------------
    assign w_next_mark  = (w_next_state == S_LEAD_MARK) || (w_next_state == S_BIT_MARK) ||
                          (w_next_state == S_STOP_MARK);
    assign w_next_timed = w_next_mark || (w_next_state == S_LEAD_SPACE) ||
                          (w_next_state == S_BIT_SPACE);
    assign w_enter_mark = w_next_mark && (w_next_state != r_state);

    // Every mark starts at carrier phase 0 so its first cycle is carrier-high
    assign w_car_next = w_enter_mark          ? '0 :
                        (r_car == c_CAR_LAST) ? '0 :
                        r_car + c_CAR_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // 1 us tick prescaler; held at zero outside the timed states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_accept || !w_timed) begin
            r_pre <= '0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    // Duration counter: advances on ticks, clears whenever the state changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dur <= '0;
        end else if (w_accept || (w_next_state != r_state)) begin
            r_dur <= '0;
        end else if (w_tick) begin
            r_dur <= r_dur + c_DUR_W'(1);
        end
    end

    // Data shift register and bit counter; one bit is consumed at the end of each bit space
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shift   <= i_data;
            r_bit_cnt <= '0;
        end else if ((r_state == S_BIT_SPACE) && w_dur_end) begin
            r_shift   <= {r_shift[30:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 6'd1;
        end
    end

    // Carrier phase counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_car  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_tx   <= 1'b0;
            r_led  <= 1'b0;
        end else begin
            r_car  <= w_car_next;
            r_busy <= w_next_timed;
            r_done <= (w_next_state == S_DONE);
            r_tx   <= w_next_mark;
            r_led  <= w_next_mark && (w_car_next < c_CAR_HALF);
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_ir_tx  = r_tx;
    assign o_ir_txb = ~r_tx;
    assign o_ir_led = r_led;

endmodule
`default_nettype wire

// File: tb/tb_ir_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_tx
//  Purpose  : Directed self-checking bench for ir_tx with scaled timing
//             parameters; measures every mark/space, decodes the frame from
//             the baseband output and checks carrier gating and handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ir_tx;

    localparam int TD = 2;
    localparam int LM = 18;
    localparam int LS = 9;
    localparam int BM = 2;
    localparam int ZS = 2;
    localparam int OS = 5;
    localparam int CD = 7;
    localparam int LIMIT = 400;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_data;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic        o_ir_tx;
    logic        o_ir_txb;
    logic        o_ir_led;

    int tests;
    int fails;
    int led_err;
    int busy_err;
    bit scramble;
    int total;

    ir_tx #(
        .TICK_DIV      (TD),
        .LEAD_MARK_US  (LM),
        .LEAD_SPACE_US (LS),
        .BIT_MARK_US   (BM),
        .ZERO_SPACE_US (ZS),
        .ONE_SPACE_US  (OS),
        .CARRIER_DIV   (CD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (i_data),
        .i_start  (i_start),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_ir_tx  (o_ir_tx),
        .o_ir_txb (o_ir_txb),
        .o_ir_led (o_ir_led)
    );

    // 100 MHz bench clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (scramble) i_data = $urandom;
    endtask

    // Length of the current o_ir_tx level, checking LED gating and busy on the way
    task automatic measure(output int n);
        logic lvl;
        logic exp_led;
        lvl = o_ir_tx;
        n   = 0;
        while ((o_ir_tx === lvl) && (n < LIMIT)) begin
            exp_led = lvl ? ((n % CD) < (CD / 2)) : 1'b0;
            if (o_ir_led !== exp_led) led_err++;
            if (o_busy !== 1'b1) busy_err++;
            if (o_ir_txb !== ~o_ir_tx) busy_err++;
            n++;
            step();
        end
    endtask

    // Caller has set i_data/i_start; the first step is the accepting edge.
    // Returns in the DONE cycle.
    task automatic check_frame(input logic [31:0] d, input bit one_shot, input string tag,
                               output int tot);
        int n;
        int exp_total;
        int mark_err;
        int space_err;
        logic [31:0] got;
        step();
        if (one_shot) i_start = 1'b0;
        chk({tag, " busy after accept"}, {31'd0, o_busy}, 32'd1);
        chk({tag, " tx after accept"}, {31'd0, o_ir_tx}, 32'd1);
        led_err   = 0;
        busy_err  = 0;
        tot       = 0;
        mark_err  = 0;
        space_err = 0;
        got       = '0;
        exp_total = TD * (LM + LS + BM);
        measure(n); tot += n;
        chk({tag, " lead mark"}, n, TD * LM);
        measure(n); tot += n;
        chk({tag, " lead space"}, n, TD * LS);
        for (int i = 0; i < 32; i++) begin
            measure(n); tot += n;
            if (n != TD * BM) mark_err++;
            measure(n); tot += n;
            got = {got[30:0], (n > TD * (ZS + OS) / 2)};
            if (n != (d[31-i] ? TD * OS : TD * ZS)) space_err++;
            exp_total += TD * BM + (d[31-i] ? TD * OS : TD * ZS);
        end
        measure(n); tot += n;
        chk({tag, " stop mark"}, n, TD * BM);
        chk({tag, " decoded word"}, got, d);
        chk({tag, " bit mark errors"}, mark_err, 0);
        chk({tag, " bit space errors"}, space_err, 0);
        chk({tag, " frame length"}, tot, exp_total);
        chk({tag, " done pulse"}, {31'd0, o_done}, 32'd1);
        chk({tag, " busy low in done"}, {31'd0, o_busy}, 32'd0);
        chk({tag, " led gating errors"}, led_err, 0);
        chk({tag, " busy/txb errors"}, busy_err, 0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        led_err  = 0;
        busy_err = 0;
        scramble = 1'b0;
        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_data   = '0;

        // Reset values
        step();
        step();
        chk("reset outputs", {27'd0, o_busy, o_done, o_ir_tx, o_ir_txb, o_ir_led}, 32'b00010);
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("idle after release", {27'd0, o_busy, o_done, o_ir_tx, o_ir_txb, o_ir_led}, 32'b00010);

        // Reference frame with a single-cycle start
        i_data  = 32'h00FF_A25D;
        i_start = 1'b1;
        check_frame(32'h00FF_A25D, 1'b1, "a25d", total);
        chk("a25d busy total", total, 410);
        step();
        chk("a25d done one cycle", {30'd0, o_done, o_busy}, 32'b00);

        // All-zero frame
        i_data  = 32'h0000_0000;
        i_start = 1'b1;
        check_frame(32'h0000_0000, 1'b1, "zero", total);
        chk("zero busy total", total, 314);
        step();

        // All-one frame
        i_data  = 32'hFFFF_FFFF;
        i_start = 1'b1;
        check_frame(32'hFFFF_FFFF, 1'b1, "ones", total);
        chk("ones busy total", total, 506);
        step();

        // Start held high while data changes; a second frame chains from DONE
        i_data   = 32'h5A5A_0FF0;
        i_start  = 1'b1;
        scramble = 1'b1;
        check_frame(32'h5A5A_0FF0, 1'b0, "held", total);
        scramble = 1'b0;
        i_data   = 32'hA5C3_0F96;
        check_frame(32'hA5C3_0F96, 1'b1, "chain", total);
        step();
        chk("chain back to idle", {30'd0, o_done, o_busy}, 32'b00);

        // Asynchronous reset in the middle of the first bit space
        i_data  = 32'hFFFF_FFFF;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 0; i < TD * (LM + LS + BM) + 2; i++) step();
        chk("in bit space", {30'd0, o_busy, o_ir_tx}, 32'b10);
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {27'd0, o_busy, o_done, o_ir_tx, o_ir_txb, o_ir_led}, 32'b00010);
        begin
            int done_seen;
            done_seen = 0;
            for (int i = 0; i < 3; i++) begin
                step();
                if (o_done !== 1'b0 || o_busy !== 1'b0 || o_ir_tx !== 1'b0) done_seen++;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                if (o_done !== 1'b0 || o_busy !== 1'b0 || o_ir_tx !== 1'b0) done_seen++;
            end
            chk("quiet after reset", done_seen, 0);
        end

        // Fresh frame after the reset
        i_data  = 32'h1234_5678;
        i_start = 1'b1;
        check_frame(32'h1234_5678, 1'b1, "post reset", total);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
